move_cmd_encoder: RTL
=====================

# move_cmd_encoder

Front-end for the lab4 game controller. Synchronizes and debounces the four raw active-low push buttons, edge-detects presses, arbitrates simultaneous presses, and issues exactly one single-cycle direction pulse per press on `up`/`down`/`left`/`right`. Those outputs drive the game state machine. A handshake with the board logic (`move_done`) guarantees that no new move is issued while the previous one is still being applied.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); minimum 2.
- `REPEAT_CYCLES`, default 25_000_000: hold time before auto-repeat re-issues a move. Used only with `MOVE_AUTO_REPEAT_EN`.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_up_n`, `btn_down_n`, `btn_left_n`, `btn_right_n`  in  1 each  raw board buttons, active-low, asynchronous to `clk`.
- `game_over`  in  1  high while the game is in the win or lose state; level.
- `move_done`  in  1  one-cycle pulse from board logic when the last issued move has been fully applied.
- `up`, `down`, `left`, `right`  out  1 each  one-cycle move command pulses; at most one high in any cycle.
- `busy`  out  1  high from the issue cycle until the handshake closes (ISSUE or WAIT_DONE).

## Operation
- Each button path:
  - 2-flop synchronizer, inverted so that 1 = pressed.
  - Debouncer: counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
    - The counter clears whenever the synchronized sample equals the debounced level.
    - The debounced level toggles on the edge where the mismatch count reaches `DEBOUNCE_CYCLES`; the counter clears at that edge.
  - Press event: debounced 0->1 transition, one cycle wide.
- Controller FSM states: IDLE, ISSUE, WAIT_DONE, RELEASE.
  - IDLE -> ISSUE: any press event and `game_over`=0. Winner is latched by fixed priority up > down > left > right. Losing simultaneous events are discarded.
  - IDLE with `game_over`=1: press events are ignored and the FSM stays in IDLE.
  - ISSUE (1 cycle): the latched direction output is high. Always -> WAIT_DONE.
  - WAIT_DONE -> RELEASE: on `move_done`=1, or on `game_over`=1. Game over closes the handshake, since no `move_done` follows.
  - RELEASE -> IDLE: once all four debounced levels are 0. Press events seen while in RELEASE are dropped.
- `move_done` outside WAIT_DONE is ignored, including in the ISSUE cycle.
- Direction outputs and `busy` are registered and decoded from state plus the latched direction.
- Reset (any time, including mid-debounce or in WAIT_DONE):
  - FSM goes to IDLE.
  - Synchronizers, debounced levels and counters clear to 0.
  - Latched direction clears to NONE.
  - All outputs are 0.
  - A button held through reset release produces a press event after debounce, because the debounced level restarts at 0.

## Timing
- Reset values: `up`=`down`=`left`=`right`=0, `busy`=0.
- Latency: the pin goes low and is first sampled at edge 0, then stays stable. The direction pulse is high in the cycle after edge `DEBOUNCE_CYCLES+3`. The pulse width is exactly 1 cycle.
- `busy` rises with the pulse. It falls in the cycle after `move_done` is sampled in WAIT_DONE.
- Minimum spacing between two issued moves: issue, then 1 cycle in WAIT_DONE, then RELEASE, then a fresh debounce.
- Pin glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.

## Configuration
- `MOVE_AUTO_REPEAT_EN` defined:
  - In RELEASE, a repeat counter runs while the originally issued button's debounced level stays 1 and the other three stay 0.
  - When the counter reaches `REPEAT_CYCLES`, the FSM goes RELEASE -> ISSUE with the same direction and the counter clears.
  - Any other button going high, or `game_over`=1, stops the repeat.
- Macro undefined: no repeat counter is built. RELEASE only waits for all buttons released. `REPEAT_CYCLES` is unused.

## Structure
- Shared package `game_pkg`:
  - `dir_t` enum: DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT.
  - `move_state_t` enum: the four FSM states.
  - Default debounce and repeat constants.
- Sub-module `button_debouncer`, instantiated 4x. It contains the synchronizer, debounce counter and press-event generator. Outputs: `level`, `press`.
- Top level holds the arbitration, FSM, direction latch and optional repeat counter.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `REPEAT_CYCLES=10`.
- Reset, then hold `btn_left_n`=0: a single `left` pulse in the cycle after edge 7, `busy`=1. Pulse `move_done` 3 cycles later: `busy`=0 next cycle. Release and repress: a second `left` pulse.
- Press `btn_down_n` and `btn_right_n` in the same cycle: only `down` pulses. Still holding `right` after `move_done`: no further pulse until both buttons are released.
- 3-cycle low glitch on `btn_up_n`: no output and `busy` stays 0. A 4-cycle stable low: `up` pulse.
- `game_over`=1 while in WAIT_DONE: `busy` falls with no `move_done`. Later presses with `game_over` held at 1: no pulses.
- Assert `reset` during WAIT_DONE: all outputs 0 immediately. A button held through reset release issues a fresh pulse after the debounce latency.
- `MOVE_AUTO_REPEAT_EN`: hold `up` with `move_done` returned promptly. Repeat `up` pulses occur every handshake + 10 cycles. Pressing `right` as well stops the repeats.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the lab4 game controller front-end.
// Direction/state enums plus button-to-direction helpers.
package game_pkg;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RELEASE
  } move_state_t;

  localparam int DEBOUNCE_DEFAULT = 500_000;
  localparam int REPEAT_DEFAULT   = 25_000_000;

  // Button vector bit order: 0 up, 1 down, 2 left, 3 right.
  function automatic dir_t pick_dir(input logic [3:0] ev);
    dir_t d;
    if (ev[0])      d = DIR_UP;
    else if (ev[1]) d = DIR_DOWN;
    else if (ev[2]) d = DIR_LEFT;
    else if (ev[3]) d = DIR_RIGHT;
    else            d = DIR_NONE;
    return d;
  endfunction

  function automatic logic [3:0] dir_mask(input dir_t d);
    logic [3:0] m;
    m = 4'b0000;
    unique case (d)
      DIR_UP:    m = 4'b0001;
      DIR_DOWN:  m = 4'b0010;
      DIR_LEFT:  m = 4'b0100;
      DIR_RIGHT: m = 4'b1000;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button path: 2-flop synchronizer, debounce counter and
// one-cycle press event on the debounced 0->1 transition.
module button_debouncer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

  logic         sync1;
  logic         sync2;
  logic         level_d;
  logic [W-1:0] cnt;

  // Bring the raw pin into clk, inverted so 1 means pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES mismatching samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge detect of the debounced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/move_cmd_encoder.sv
// Button front-end: debounce, arbitrate, issue one move per press.
// Optional auto-repeat while held: define MOVE_AUTO_REPEAT_EN.
module move_cmd_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_n,
  input  logic btn_down_n,
  input  logic btn_left_n,
  input  logic btn_right_n,
  input  logic game_over,
  input  logic move_done,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic busy
);

  logic [3:0]  lvl;
  logic [3:0]  prs;
  logic [3:0]  btn_n;
  move_state_t state;
  move_state_t state_nx;
  dir_t        dir;
  dir_t        dir_nx;
  logic        rpt_fire;

  assign btn_n = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[i]),
      .level (lvl[i]),
      .press (prs[i])
    );
  end

`ifdef MOVE_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_stop;
  logic          hold_ok;

  assign hold_ok  = (lvl == dir_mask(dir)) && !game_over && !rpt_stop;
  assign rpt_fire = (state == RELEASE) && hold_ok && (rpt_cnt == RLAST);

  // Hold timer; any disturbance stops repeating until the next release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt  <= '0;
      rpt_stop <= 1'b0;
    end else if (state != RELEASE) begin
      rpt_cnt  <= '0;
      rpt_stop <= 1'b0;
    end else if (!hold_ok) begin
      rpt_cnt  <= '0;
      rpt_stop <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_CYCLES > 0);
  assign rpt_fire = 1'b0;
`endif

  // Next-state, arbitration and direction latch.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    unique case (state)
      IDLE: begin
        if (|prs && !game_over) begin
          state_nx = ISSUE;
          dir_nx   = pick_dir(prs);
        end
      end
      ISSUE: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (move_done || game_over) state_nx = RELEASE;
      end
      RELEASE: begin
        if (lvl == 4'b0000) begin
          state_nx = IDLE;
          dir_nx   = DIR_NONE;
        end else if (rpt_fire) begin
          state_nx = ISSUE;
        end
      end
      default: begin
        state_nx = IDLE;
        dir_nx   = DIR_NONE;
      end
    endcase
  end

  // State and latched direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= DIR_NONE;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
    end
  end

  // Registered outputs decoded from the upcoming state and direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      busy  <= 1'b0;
    end else begin
      up    <= (state_nx == ISSUE) && (dir_nx == DIR_UP);
      down  <= (state_nx == ISSUE) && (dir_nx == DIR_DOWN);
      left  <= (state_nx == ISSUE) && (dir_nx == DIR_LEFT);
      right <= (state_nx == ISSUE) && (dir_nx == DIR_RIGHT);
      busy  <= (state_nx == ISSUE) || (state_nx == WAIT_DONE);
    end
  end

endmodule
